psum_rx_link: RTL



---
 rtl/psum_link_pkg.sv | 17 +
 rtl/psum_rx_fifo.sv | 49 ++++
 rtl/psum_rx_link.sv | 115 +++++++++++
 3 files changed

// File: rtl/psum_link_pkg.sv
// Shared definitions for both ends of the inter-core partial-sum link.
// Used by the receive block (psum_rx_link) and the peer's transmit block.
package psum_link_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } link_state_t;

  localparam int DEFAULT_DEPTH = 4;

  // Exchanged sum carries four guard bits above the core partial sum.
  function automatic int sum_w(input int bw_psum);
    return bw_psum + 4;
  endfunction

endpackage

// File: rtl/psum_rx_fifo.sv
// Synchronous FIFO buffering peer partial sums until a local sum is ready.
// The caller only pushes when there is room (or when it pops on the same edge).
module psum_rx_fifo #(
  parameter int width = 24,
  parameter int depth = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [width-1:0]       push_data,
  input  logic                   pop,
  output logic [width-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(depth):0] count
);

  localparam int AW = $clog2(depth);

  logic [width-1:0] mem [depth];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // depth is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (count == (AW+1)'(depth));
  assign empty    = (count == '0);

endmodule

// File: rtl/psum_rx_link.sv
// Receive end of the inter-core partial-sum link: 4-phase req/ack responder,
// peer-sum FIFO, local holding register and adder. Option: PSUM_RX_SYNC_EN.
module psum_rx_link
  import psum_link_pkg::*;
#(
  parameter int bw      = 8,
  parameter int bw_psum = 2*bw + 4,
  parameter int depth   = DEFAULT_DEPTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        rx_req,
  input  logic [sum_w(bw_psum)-1:0]   rx_sum_in,
  output logic                        rx_ack,
  input  logic                        loc_valid,
  input  logic [sum_w(bw_psum)-1:0]   loc_sum,
  output logic                        loc_ready,
  output logic                        sum_valid,
  output logic [sum_w(bw_psum):0]     sum_total,
  output logic [$clog2(depth):0]      fifo_cnt,
  output link_state_t                 link_state
);

  localparam int SW = sum_w(bw_psum);

  // Handshake valid/ready: rx_sum_in is pushed on the edge that leaves IDLE
  // with req_s high and room in the FIFO; loc_sum is taken when
  // loc_valid && loc_ready; sum_total is valid only while sum_valid is high.

  logic          req_s;
  logic          push;
  logic          combine;
  logic          can_push;
  logic          fifo_full;
  logic          fifo_empty;
  logic [SW-1:0] fifo_head;
  logic          loc_full;
  logic [SW-1:0] loc_reg;
  logic          load;
  link_state_t   state;
  link_state_t   state_next;

`ifdef PSUM_RX_SYNC_EN
  logic [1:0] req_sync;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) req_sync <= '0;
    else       req_sync <= {req_sync[0], rx_req};
  end
  assign req_s = req_sync[1];
`else
  assign req_s = rx_req;
`endif

  // A pop on the same edge frees a slot, so a full FIFO may still accept.
  assign can_push = !fifo_full || combine;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_s && can_push) state_next = HOLD;
      HOLD:    if (!req_s)            state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    push   = (state == IDLE) && req_s && can_push;
    rx_ack = (state == HOLD);
  end

  assign link_state = state;

  assign combine   = loc_full && !fifo_empty;
  assign loc_ready = !loc_full || combine;
  assign load      = loc_valid && loc_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      loc_full  <= 1'b0;
      loc_reg   <= '0;
      sum_valid <= 1'b0;
      sum_total <= '0;
    end else begin
      sum_valid <= combine;
      if (combine) sum_total <= {1'b0, loc_reg} + {1'b0, fifo_head};
      if (load) begin
        loc_full <= 1'b1;
        loc_reg  <= loc_sum;
      end else if (combine) begin
        loc_full <= 1'b0;
      end
    end
  end

  psum_rx_fifo #(
    .width (SW),
    .depth (depth)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (rx_sum_in),
    .pop       (combine),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );

endmodule
